// File: rtl/gray_codec_stream.sv
// Streaming binary<->Gray converter with a registered valid/ready output stage
// and an optional single-bit-step checker kept in the Gray domain.
module gray_codec_stream #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned ERR_W    = 8,
    parameter bit          CHECK_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_step_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic             accept_c;
    logic [WIDTH-1:0] gray_c;
    logic [WIDTH-1:0] bin_c;
    logic [WIDTH-1:0] conv_c;
    logic [WIDTH-1:0] chk_gray_c;
    logic             step_err_c;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_mode_q, out_mode_d;
    logic             out_step_err_q, out_step_err_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept_c = in_valid && in_ready;

    // Gray->binary bit i is the XOR of all input bits from i up to the MSB.
    always_comb begin
        gray_c = in_data ^ (in_data >> 1);
        bin_c  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            bin_c[i] = ^(in_data >> i);
        end
        conv_c     = in_mode ? bin_c : gray_c;
        chk_gray_c = in_mode ? in_data : gray_c;
    end

    always_comb begin
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_mode_d     = out_mode_q;
        out_step_err_d = out_step_err_q;
        if (accept_c) begin
            out_valid_d    = 1'b1;
            out_data_d     = conv_c;
            out_mode_d     = in_mode;
            out_step_err_d = step_err_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_mode_q     <= 1'b0;
            out_step_err_q <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_mode_q     <= out_mode_d;
            out_step_err_q <= out_step_err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_mode     = out_mode_q;
    assign out_step_err = out_step_err_q;

    generate
        if (CHECK_EN) begin : g_chk
            logic [WIDTH-1:0] hist_q, hist_d;
            logic             hist_vld_q, hist_vld_d;
            logic [ERR_W-1:0] err_q, err_d;
            logic [WIDTH-1:0] diff_c;
            logic             legal_c;

            // A beat accepted together with clr is exempt and seeds fresh history.
            always_comb begin
                diff_c     = chk_gray_c ^ hist_q;
                legal_c    = (diff_c != '0) && ((diff_c & (diff_c - WIDTH'(1))) == '0);
                hist_d     = hist_q;
                hist_vld_d = hist_vld_q;
                err_d      = err_q;
                step_err_c = 1'b0;
                if (accept_c) begin
                    step_err_c = hist_vld_q && !clr && !legal_c;
                    hist_d     = chk_gray_c;
                    hist_vld_d = 1'b1;
                end else if (clr) begin
                    hist_vld_d = 1'b0;
                end
                if (clr) begin
                    err_d = '0;
                end else if (step_err_c && (err_q != ERR_MAX)) begin
                    err_d = err_q + ERR_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hist_q     <= '0;
                    hist_vld_q <= 1'b0;
                    err_q      <= '0;
                end else begin
                    hist_q     <= hist_d;
                    hist_vld_q <= hist_vld_d;
                    err_q      <= err_d;
                end
            end

            assign err_count = err_q;
        end else begin : g_nochk
            assign step_err_c = 1'b0;
            assign err_count  = '0;
        end
    endgenerate

endmodule

// File: tb/tb_gray_codec_stream.sv
// Directed self-checking bench for gray_codec_stream (WIDTH=4, ERR_W=2).
module tb_gray_codec_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic       in_mode;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_mode;
    logic       out_step_err;
    logic [1:0] err_count;

    int vectors    = 0;
    int miscompares = 0;

    gray_codec_stream #(.WIDTH(4), .ERR_W(2), .CHECK_EN(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_mode     (out_mode),
        .out_step_err (out_step_err),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
        in_data = 4'd0; out_ready = 1'b1;
        #12;
        vectors++;
        if ({out_valid, out_data, out_mode, out_step_err, err_count} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_state got v=%b d=%b m=%b e=%b c=%0d want all zero",
                     out_valid, out_data, out_mode, out_step_err, err_count);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_bin_to_gray();
        logic [3:0] din [5] = '{4'b1010, 4'b1001, 4'b1000, 4'b0110, 4'b0101};
        logic [3:0] dexp[5] = '{4'b1111, 4'b1101, 4'b1100, 4'b0101, 4'b0111};
        logic       eexp[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0] cexp[5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        in_mode = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = din[i];
            tick();
            vectors++;
            if ({out_valid, out_mode, out_data, out_step_err, err_count} !==
                {1'b1, 1'b0, dexp[i], eexp[i], cexp[i]}) begin
                miscompares++;
                $display("FAIL b2g_beat%0d got v=%b m=%b d=%b e=%b c=%0d want v=1 m=0 d=%b e=%b c=%0d",
                         i, out_valid, out_mode, out_data, out_step_err, err_count,
                         dexp[i], eexp[i], cexp[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2g_drain out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_gray_to_bin();
        logic [3:0] gin[17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        logic [3:0] bexp;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++;
        if (err_count !== 2'd0) begin
            miscompares++;
            $display("FAIL clr_idle err_count got %0d want 0", err_count);
        end
        in_mode = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = gin[i];
            bexp = (i == 16) ? 4'd0 : 4'(i);
            tick();
            vectors++;
            if ({out_valid, out_mode, out_data, out_step_err, err_count} !==
                {1'b1, 1'b1, bexp, 1'b0, 2'd0}) begin
                miscompares++;
                $display("FAIL g2b_beat%0d got v=%b m=%b d=%b e=%b c=%0d want v=1 m=1 d=%b e=0 c=0",
                         i, out_valid, out_mode, out_data, out_step_err, err_count, bexp);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    // History is Gray 0000; binary 0001 -> 0001, 0010 -> 0011, 0011 -> 0010.
    task automatic test_backpressure();
        logic [3:0] exp_q[$];
        logic [3:0] got;
        in_mode = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'b0001; exp_q.push_back(4'b0001);
        tick();
        out_ready = 1'b0; in_data = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready);
            end
            tick();
            vectors++;
            if ({out_valid, out_data, out_mode, out_step_err} !== {1'b1, 4'b0001, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL bp_hold%0d got v=%b d=%b m=%b e=%b want v=1 d=0001 m=0 e=0",
                         i, out_valid, out_data, out_mode, out_step_err);
            end
        end
        got = out_data;
        vectors++;
        if (got !== exp_q.pop_front()) begin
            miscompares++;
            $display("FAIL bp_sb_first got %b want 0001", got);
        end
        out_ready = 1'b1;
        exp_q.push_back(4'b0011);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_ready got %b want 1", in_ready);
        end
        tick();
        in_data = 4'b0011; exp_q.push_back(4'b0010);
        for (int i = 0; i < 2; i++) begin
            got = out_data;
            vectors++;
            if (!out_valid || out_step_err || got !== exp_q[0]) begin
                miscompares++;
                $display("FAIL bp_sb_beat%0d got v=%b d=%b e=%b want v=1 d=%b e=0",
                         i, out_valid, got, out_step_err, exp_q[0]);
            end
            void'(exp_q.pop_front());
            if (i == 0) tick();
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_drain got v=%b left=%0d want v=0 left=0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_saturate();
        logic       eexp[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] cexp[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_mode = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 4'b0000;
            tick();
            vectors++;
            if ({out_data, out_step_err, err_count} !== {4'b0000, eexp[i], cexp[i]}) begin
                miscompares++;
                $display("FAIL sat_beat%0d got d=%b e=%b c=%0d want d=0000 e=%b c=%0d",
                         i, out_data, out_step_err, err_count, eexp[i], cexp[i]);
            end
        end
    endtask

    task automatic test_clr_with_accept();
        in_mode = 1'b1; in_valid = 1'b1; in_data = 4'b0011; clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++;
        if ({out_valid, out_data, out_step_err, err_count} !== {1'b1, 4'b0010, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL clr_accept got v=%b d=%b e=%b c=%0d want v=1 d=0010 e=0 c=0",
                     out_valid, out_data, out_step_err, err_count);
        end
        in_data = 4'b0001;
        tick();
        vectors++;
        if ({out_data, out_step_err, err_count} !== {4'b0001, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL clr_next got d=%b e=%b c=%0d want d=0001 e=0 c=0",
                     out_data, out_step_err, err_count);
        end
    endtask

    task automatic test_async_reset();
        in_mode = 1'b1; in_valid = 1'b1; in_data = 4'b0001;
        tick();
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        vectors++;
        if ({out_valid, err_count} !== {1'b1, 2'd2}) begin
            miscompares++;
            $display("FAIL arst_setup got v=%b c=%0d want v=1 c=2", out_valid, err_count);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_data, out_step_err, err_count} !== 8'd0) begin
            miscompares++;
            $display("FAIL arst_immediate got v=%b d=%b e=%b c=%0d want all zero",
                     out_valid, out_data, out_step_err, err_count);
        end
        #1 rst_n = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 4'b0001;
        tick();
        vectors++;
        if ({out_valid, out_data, out_step_err, err_count} !== {1'b1, 4'b0001, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL arst_exempt got v=%b d=%b e=%b c=%0d want v=1 d=0001 e=0 c=0",
                     out_valid, out_data, out_step_err, err_count);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({out_step_err, err_count} !== {1'b1, 2'd1}) begin
            miscompares++;
            $display("FAIL arst_live got e=%b c=%0d want e=1 c=1", out_step_err, err_count);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_bin_to_gray();
        test_gray_to_bin();
        test_backpressure();
        test_saturate();
        test_clr_with_accept();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
